fetch_branch_history: RTL
=========================

# fetch_branch_history

Speculative global-branch-history manager in the fetch stage, directly upstream of checkpoint_buffer. For each branch leaving fetch it reserves a checkpoint ID, pushes a checkpoint snapshot of the pre-branch global history, and shifts the predicted direction into the speculative history. On a mispredict from exbru it repairs the history from the checkpoint. It also tracks committed (architectural) history, which it uses to recover on a commit flush.

## Interface
Parameters (from config.svh; no module parameters):
- GLOBAL_HISTORY_WIDTH, n/a: speculative and architectural history length in bits; minimum 2.
- CHECKPOINT_ID_WIDTH, n/a: checkpoint ID width.
- COMMIT_WIDTH, n/a: commit slots per cycle.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- fetch_bhu_valid  in  1  a branch is leaving fetch this cycle.
- fetch_bhu_pred_taken  in  1  predicted direction of that branch.
- bhu_fetch_stall  out  1  branch not accepted; fetch holds it.
- bhu_fetch_checkpoint_id  out  CHECKPOINT_ID_WIDTH  ID assigned to the accepted branch.
- bhu_fetch_global_history  out  GLOBAL_HISTORY_WIDTH  current speculative history, used for predictor indexing.
- cpbuf_fetch_new_id  in  CHECKPOINT_ID_WIDTH  next free checkpoint ID.
- cpbuf_fetch_new_id_valid  in  1  the checkpoint buffer has a free entry.
- fetch_cpbuf_data  out  checkpoint_t  snapshot to push.
- fetch_cpbuf_push  out  1  push strobe.
- exbru_bhu_mispredict  in  1  a branch resolved mispredicted this cycle.
- exbru_bhu_actual_taken  in  1  resolved direction of that branch.
- cpbuf_exbru_data  in  checkpoint_t  checkpoint of the mispredicted branch.
- commit_bhu_branch_valid  in  COMMIT_WIDTH  per-slot flag: a committed branch is in this slot.
- commit_bhu_taken  in  COMMIT_WIDTH  per-slot committed direction.
- commit_cpbuf_flush  in  1  pipeline flush from commit.

## Operation
State registers:
- spec_ghr: speculative history. Reset value 0.
- arch_ghr: architectural history. Reset value 0.

History shift rule: shift(h, t) = {h[W-2:0], t}, where W = GLOBAL_HISTORY_WIDTH. The newest outcome goes in the LSB; the oldest outcome drops out.

Commit path:
- arch_next is arch_ghr shifted once per valid slot, processing slots 0 to COMMIT_WIDTH-1 in order.
- Slots that are not valid do not shift.
- arch_ghr <= arch_next every cycle.

Priority per cycle: flush, then mispredict, then fetch.
- Flush: spec_ghr <= arch_next, so the history includes same-cycle commits. Push is 0 and stall is 1.
- Mispredict (no flush): spec_ghr <= shift(cpbuf_exbru_data.global_history, exbru_bhu_actual_taken). Push is 0 and stall is 1.
- Fetch accept (fetch_bhu_valid and cpbuf_fetch_new_id_valid, with no flush or mispredict):
  - fetch_cpbuf_push is 1.
  - fetch_cpbuf_data.global_history is spec_ghr before the update.
  - All other checkpoint fields are 0; rename fills in the RAT fields later.
  - bhu_fetch_checkpoint_id is cpbuf_fetch_new_id.
  - spec_ghr <= shift(spec_ghr, fetch_bhu_pred_taken).
- Fetch blocked (fetch_bhu_valid and not cpbuf_fetch_new_id_valid): stall is 1, push is 0, spec_ghr is held.
- No branch (fetch_bhu_valid is 0): push is 0, stall is 0, spec_ghr is held.
- bhu_fetch_checkpoint_id always mirrors cpbuf_fetch_new_id.
- bhu_fetch_global_history always equals spec_ghr.

## Timing
- push, stall and checkpoint_id are combinational from the same-cycle inputs; there is zero latency to the checkpoint buffer.
- History updates become visible on bhu_fetch_global_history one cycle after the triggering event.
- Output values during reset:
  - bhu_fetch_global_history = 0.
  - fetch_cpbuf_push = 0 while fetch_bhu_valid = 0.
  - bhu_fetch_stall = 0 while fetch_bhu_valid = 0.
- Reset asserted mid-operation clears both history registers immediately, without waiting for a clock edge.
- A checkpoint buffer that becomes full and then empties needs no internal state; acceptance resumes in the same cycle cpbuf_fetch_new_id_valid returns to 1.
- A mispredict together with a commit in the same cycle: arch_ghr still takes the commits.
- A flush together with a mispredict: the flush wins.

## Configuration
- BRANCH_HISTORY_PERF_COUNTER_EN defined:
  - Adds bhu_perf_stall_count (out, 32 bits). It increments each cycle that bhu_fetch_stall = 1 and fetch_bhu_valid = 1.
  - Adds bhu_perf_mispredict_count (out, 32 bits). It increments on each mispredict that is not overridden by a flush.
  - Both counters saturate at all-ones and reset to 0.
- BRANCH_HISTORY_PERF_COUNTER_EN undefined: the counter ports and logic are absent; behaviour is otherwise identical.

## Structure
- Shared package (common.svh):
  - checkpoint_t, which already exists.
  - A ghr_shift function.
  - A global_history_t typedef of width GLOBAL_HISTORY_WIDTH.
- Sub-module ghr_commit_shifter: a combinational, in-order, COMMIT_WIDTH-slot shift of arch_ghr that produces arch_next.

## Test plan
Bench configuration: GLOBAL_HISTORY_WIDTH = 8, checkpoint buffer size 4.
- Reset, then fetch_bhu_valid=1 with pred_taken=1 on 3 consecutive cycles, IDs 0, 1, 2 valid -> pushes carry global_history 0x00, 0x01, 0x03; final spec_ghr is 0x07.
- fetch_bhu_valid=1 with cpbuf_fetch_new_id_valid=0 for 2 cycles -> stall=1 and push=0 each cycle; spec_ghr unchanged; with the macro defined, the stall counter reads 2.
- Mispredict with cpbuf_exbru_data.global_history=0x01, actual_taken=0, and fetch_bhu_valid=1 in the same cycle -> push=0; next-cycle spec_ghr is 0x02.
- Commit slots 0 and 1 valid with taken=1,0 -> arch_ghr goes from 0x00 to 0x02. A flush in the same cycle -> spec_ghr is 0x02 on the next cycle.
- Flush and mispredict in the same cycle, with arch_ghr=0x05 and no commits -> spec_ghr is 0x05; the mispredict counter is unchanged.
- Drop rst to 0 asynchronously mid-stream with spec_ghr=0x3C -> bhu_fetch_global_history is 0 before the next clk edge.

Source files
------------

// File: rtl/fetch_branch_history_pkg.sv
// Shared types and helpers for the fetch-stage branch history manager.
// History/ID/commit widths mirror the core configuration.
package fetch_branch_history_pkg;

   localparam int GLOBAL_HISTORY_WIDTH = 8;
   localparam int CHECKPOINT_ID_WIDTH  = 2;
   localparam int COMMIT_WIDTH         = 2;
   localparam int RAT_CKPT_WIDTH       = 16;

   typedef logic [GLOBAL_HISTORY_WIDTH-1:0] global_history_t;
   typedef logic [CHECKPOINT_ID_WIDTH-1:0]  checkpoint_id_t;

   typedef struct packed {
      global_history_t           global_history;
      logic [RAT_CKPT_WIDTH-1:0] rat_ckpt;
   } checkpoint_t;

   // Newest outcome enters at the LSB, oldest drops out of the MSB.
   function automatic global_history_t ghr_shift(input global_history_t h, input logic t);
      return {h[GLOBAL_HISTORY_WIDTH-2:0], t};
   endfunction

endpackage

// File: rtl/fetch_branch_history_if.sv
// Fetch / checkpoint-buffer / exbru / commit signals seen by the history manager.
interface fetch_branch_history_if;
   import fetch_branch_history_pkg::*;

   logic                    fetch_bhu_valid;
   logic                    fetch_bhu_pred_taken;
   logic                    bhu_fetch_stall;
   checkpoint_id_t          bhu_fetch_checkpoint_id;
   global_history_t         bhu_fetch_global_history;
   checkpoint_id_t          cpbuf_fetch_new_id;
   logic                    cpbuf_fetch_new_id_valid;
   checkpoint_t             fetch_cpbuf_data;
   logic                    fetch_cpbuf_push;
   logic                    exbru_bhu_mispredict;
   logic                    exbru_bhu_actual_taken;
   checkpoint_t             cpbuf_exbru_data;
   logic [COMMIT_WIDTH-1:0] commit_bhu_branch_valid;
   logic [COMMIT_WIDTH-1:0] commit_bhu_taken;
   logic                    commit_cpbuf_flush;

   modport slave (
      input  fetch_bhu_valid, fetch_bhu_pred_taken, cpbuf_fetch_new_id,
             cpbuf_fetch_new_id_valid, exbru_bhu_mispredict, exbru_bhu_actual_taken,
             cpbuf_exbru_data, commit_bhu_branch_valid, commit_bhu_taken, commit_cpbuf_flush,
      output bhu_fetch_stall, bhu_fetch_checkpoint_id, bhu_fetch_global_history,
             fetch_cpbuf_data, fetch_cpbuf_push
   );

   modport master (
      output fetch_bhu_valid, fetch_bhu_pred_taken, cpbuf_fetch_new_id,
             cpbuf_fetch_new_id_valid, exbru_bhu_mispredict, exbru_bhu_actual_taken,
             cpbuf_exbru_data, commit_bhu_branch_valid, commit_bhu_taken, commit_cpbuf_flush,
      input  bhu_fetch_stall, bhu_fetch_checkpoint_id, bhu_fetch_global_history,
             fetch_cpbuf_data, fetch_cpbuf_push
   );

endinterface

// File: rtl/fetch_branch_history_ghr_commit_shifter.sv
// In-order shift of the architectural history by every valid commit slot.
module ghr_commit_shifter
   import fetch_branch_history_pkg::*;
(
   input  global_history_t         arch_ghr,
   input  logic [COMMIT_WIDTH-1:0] branch_valid,
   input  logic [COMMIT_WIDTH-1:0] taken,
   output global_history_t         arch_next
);

   logic [COMMIT_WIDTH:0][GLOBAL_HISTORY_WIDTH-1:0] stage;

   assign stage[0] = arch_ghr;

   for (genvar i = 0; i < COMMIT_WIDTH; i++) begin : g_slot
      assign stage[i+1] = branch_valid[i] ? ghr_shift(stage[i], taken[i]) : stage[i];
   end

   assign arch_next = stage[COMMIT_WIDTH];

endmodule

// File: rtl/fetch_branch_history.sv
// Speculative/architectural global branch history manager in fetch.
// Optional perf counters: define BRANCH_HISTORY_PERF_COUNTER_EN.
module fetch_branch_history
   import fetch_branch_history_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
`ifdef BRANCH_HISTORY_PERF_COUNTER_EN
   output logic [31:0]            bhu_perf_stall_count,
   output logic [31:0]            bhu_perf_mispredict_count,
`endif
   fetch_branch_history_if.slave  bif
);

   global_history_t spec_ghr, spec_next;
   global_history_t arch_ghr, arch_next;

   ghr_commit_shifter u_commit_shifter (
      .arch_ghr     (arch_ghr),
      .branch_valid (bif.commit_bhu_branch_valid),
      .taken        (bif.commit_bhu_taken),
      .arch_next    (arch_next)
   );

   // RAT fields of the mispredict checkpoint are irrelevant to history repair.
   logic unused_rat;
   assign unused_rat = ^bif.cpbuf_exbru_data.rat_ckpt;

   always_comb begin
      spec_next                 = spec_ghr;
      bif.fetch_cpbuf_push      = 1'b0;
      bif.bhu_fetch_stall       = 1'b0;
      bif.fetch_cpbuf_data      = '0;
      if (bif.commit_cpbuf_flush) begin
         spec_next           = arch_next;
         bif.bhu_fetch_stall = 1'b1;
      end else if (bif.exbru_bhu_mispredict) begin
         spec_next           = ghr_shift(bif.cpbuf_exbru_data.global_history,
                                         bif.exbru_bhu_actual_taken);
         bif.bhu_fetch_stall = 1'b1;
      end else if (bif.fetch_bhu_valid) begin
         if (bif.cpbuf_fetch_new_id_valid) begin
            bif.fetch_cpbuf_push                = 1'b1;
            bif.fetch_cpbuf_data.global_history = spec_ghr;
            spec_next                           = ghr_shift(spec_ghr, bif.fetch_bhu_pred_taken);
         end else begin
            bif.bhu_fetch_stall = 1'b1;
         end
      end
   end

   assign bif.bhu_fetch_checkpoint_id  = bif.cpbuf_fetch_new_id;
   assign bif.bhu_fetch_global_history = spec_ghr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         spec_ghr <= '0;
         arch_ghr <= '0;
      end else begin
         spec_ghr <= spec_next;
         arch_ghr <= arch_next;
      end
   end

`ifdef BRANCH_HISTORY_PERF_COUNTER_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bhu_perf_stall_count      <= '0;
         bhu_perf_mispredict_count <= '0;
      end else begin
         if (bif.bhu_fetch_stall && bif.fetch_bhu_valid && !(&bhu_perf_stall_count))
            bhu_perf_stall_count <= bhu_perf_stall_count + 32'd1;
         if (bif.exbru_bhu_mispredict && !bif.commit_cpbuf_flush && !(&bhu_perf_mispredict_count))
            bhu_perf_mispredict_count <= bhu_perf_mispredict_count + 32'd1;
      end
   end
`endif

endmodule
